// File: rtl/ppu_pkg.sv
// Shared PPU-side types and constants: OAM DMA state encoding and register map.
package ppu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } oam_dma_state_t;

    localparam logic [2:0]  PPU_REG_OAMDATA = 3'd4;
    localparam logic [15:0] OAM_DMA_ADDR    = 16'h4014;
    localparam int unsigned OAM_CNT_W       = 9;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA initiator: on a $4014 write, halts the CPU and copies one page of
// CPU memory into PPU OAMDATA through the PPU register port.
// Optional macro DMA_ALIGN_EN adds the odd-cycle ALIGN state.
module oam_dma
    import ppu_pkg::*;
#(
    parameter int unsigned XFER_LEN     = 256,
    parameter logic [2:0]  OAM_REG_ADDR = PPU_REG_OAMDATA
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dma_start,
    input  logic [7:0]  dma_page,
    input  logic        cpu_odd_cycle,
    output logic        cpu_rdy,
    output logic        busy,
    output logic        done,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data_in,
    output logic        ppu_reg_cs,
    output logic        ppu_reg_we,
    output logic [2:0]  ppu_reg_addr,
    output logic [7:0]  ppu_data_out
);

    localparam logic [OAM_CNT_W-1:0] XFER_LEN_C = OAM_CNT_W'(XFER_LEN);

    oam_dma_state_t         state, state_n;
    logic [7:0]             page, page_n;
    logic [OAM_CNT_W-1:0]   count, count_n;

    logic                   cpu_rdy_n, busy_n, done_n, mem_rd_n;
    logic [15:0]            mem_addr_n;
    logic                   ppu_reg_cs_n, ppu_reg_we_n;
    logic [2:0]             ppu_reg_addr_n;

`ifndef DMA_ALIGN_EN
    logic unused_odd_cycle;
    assign unused_odd_cycle = cpu_odd_cycle;
`endif

    // State, page and byte-count registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            page  <= 8'h00;
            count <= '0;
        end else begin
            state <= state_n;
            page  <= page_n;
            count <= count_n;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they register cleanly
    always_comb begin
        state_n        = state;
        page_n         = page;
        count_n        = count;
        done_n         = 1'b0;

        case (state)
            IDLE: begin
                if (dma_start) begin
                    page_n  = dma_page;
                    count_n = '0;
                    state_n = HALT;
                end
            end
            HALT: begin
`ifdef DMA_ALIGN_EN
                state_n = cpu_odd_cycle ? ALIGN : READ;
`else
                state_n = READ;
`endif
            end
            ALIGN: state_n = READ;
            READ:  state_n = WRITE;
            WRITE: begin
                count_n = OAM_CNT_W'(count + OAM_CNT_W'(1));
                if (count_n == XFER_LEN_C) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    state_n = READ;
                end
            end
            default: state_n = IDLE;
        endcase

        cpu_rdy_n      = (state_n == IDLE);
        busy_n         = (state_n != IDLE);
        mem_rd_n       = (state_n == READ);
        mem_addr_n     = (state_n == READ) ? {page_n, count_n[7:0]} : 16'h0000;
        ppu_reg_cs_n   = (state_n == WRITE);
        ppu_reg_we_n   = (state_n == WRITE);
        ppu_reg_addr_n = (state_n == WRITE) ? OAM_REG_ADDR : 3'd0;
    end

    // Registered bus-side outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_rdy      <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            mem_rd       <= 1'b0;
            mem_addr     <= 16'h0000;
            ppu_reg_cs   <= 1'b0;
            ppu_reg_we   <= 1'b0;
            ppu_reg_addr <= 3'd0;
        end else begin
            cpu_rdy      <= cpu_rdy_n;
            busy         <= busy_n;
            done         <= done_n;
            mem_rd       <= mem_rd_n;
            mem_addr     <= mem_addr_n;
            ppu_reg_cs   <= ppu_reg_cs_n;
            ppu_reg_we   <= ppu_reg_we_n;
            ppu_reg_addr <= ppu_reg_addr_n;
        end
    end

    // Read data flows straight to the PPU during the write cycle
    assign ppu_data_out = (state == WRITE) ? mem_data_in : 8'h00;

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: cycle-indexed reference model plus directed
// and randomized transfers.
module tb_oam_dma;

    localparam int LEN = 256;
`ifdef DMA_ALIGN_EN
    localparam int ALIGN_ON = 1;
`else
    localparam int ALIGN_ON = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dma_start = 1'b0;
    logic [7:0]  dma_page = 8'h00;
    logic        cpu_odd_cycle = 1'b0;
    logic        cpu_rdy, busy, done, mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data_in = 8'h00;
    logic        ppu_reg_cs, ppu_reg_we;
    logic [2:0]  ppu_reg_addr;
    logic [7:0]  ppu_data_out;

    logic [7:0]  mem [0:65535];

    oam_dma dut (
        .clk(clk), .reset(rst), .dma_start(dma_start), .dma_page(dma_page),
        .cpu_odd_cycle(cpu_odd_cycle), .cpu_rdy(cpu_rdy), .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data_in(mem_data_in),
        .ppu_reg_cs(ppu_reg_cs), .ppu_reg_we(ppu_reg_we),
        .ppu_reg_addr(ppu_reg_addr), .ppu_data_out(ppu_data_out)
    );

    always #5 clk = ~clk;

    // CPU memory with one-clock read latency
    always @(posedge clk) if (mem_rd) mem_data_in <= mem[mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a transfer accepted in cycle s with page P and alignment a
    // is busy in cycles s+1..s+1+a+2*LEN; byte k is read at s+2+a+2k and
    // written one cycle later; done pulses in the cycle after the last write.
    bit          m_active = 1'b0;
    int          m_s = 0;
    logic [7:0]  m_p = 8'h00;
    int          m_a = 0;
    int          rel, last, j;
    logic        e_rdy, e_busy, e_done, e_rd, e_cs, e_we;
    logic [15:0] e_addr;
    logic [2:0]  e_ra;
    logic [7:0]  e_dout;

    // Tallies for the directed expectations
    int          done_cnt = 0, done_cyc = 0, wr_cnt = 0, off_page_rd = 0;
    int          rdy_run = 0, last_rdy_run = 0;
    logic [15:0] last_rd = 16'h0000;
    logic [7:0]  first_wr_data = 8'h00, last_wr_data = 8'h00;

    // Per-cycle compare against the model, then advance the model
    always @(negedge clk) begin
        e_rdy = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_rd = 1'b0; e_addr = 16'h0000;
        e_cs = 1'b0; e_we = 1'b0; e_ra = 3'd0; e_dout = 8'h00;
        rel = 0; last = 0;
        if (rst) begin
            m_active = 1'b0;
        end else if (m_active) begin
            rel  = cyc - m_s;
            last = 1 + m_a + 2 * LEN;
            if (rel >= 1 && rel <= last) begin
                e_rdy = 1'b0; e_busy = 1'b1;
                if (rel >= 2 + m_a) begin
                    j = rel - 2 - m_a;
                    if (j % 2 == 0) begin
                        e_rd = 1'b1; e_addr = {m_p, 8'(j / 2)};
                    end else begin
                        e_cs = 1'b1; e_we = 1'b1; e_ra = 3'd4;
                        e_dout = mem[{m_p, 8'(j / 2)}];
                    end
                end
            end else if (rel == last + 1) begin
                e_done = 1'b1;
            end
        end
        chk("cpu_rdy", 32'(cpu_rdy), 32'(e_rdy));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("mem_rd", 32'(mem_rd), 32'(e_rd));
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("ppu_reg_cs", 32'(ppu_reg_cs), 32'(e_cs));
        chk("ppu_reg_we", 32'(ppu_reg_we), 32'(e_we));
        chk("ppu_reg_addr", 32'(ppu_reg_addr), 32'(e_ra));
        chk("ppu_data_out", 32'(ppu_data_out), 32'(e_dout));

        if (done) begin done_cnt++; done_cyc = cyc; end
        if (ppu_reg_we) begin
            if (wr_cnt == 0) first_wr_data = ppu_data_out;
            last_wr_data = ppu_data_out;
            wr_cnt++;
        end
        if (mem_rd) begin
            last_rd = mem_addr;
            if (mem_addr[15:8] != m_p) off_page_rd++;
        end
        if (cpu_rdy) rdy_run++;
        else begin
            if (rdy_run > 0) last_rdy_run = rdy_run;
            rdy_run = 0;
        end

        if (!rst) begin
            if (m_active && rel == 1) m_a = ALIGN_ON ? int'(cpu_odd_cycle) : 0;
            if (m_active && rel > last) m_active = 1'b0;
            if (!(m_active && rel >= 1 && rel <= last) && dma_start) begin
                m_active = 1'b1; m_s = cyc; m_p = dma_page; m_a = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cpu_odd_cycle = 1'($urandom_range(0, 1));
    endtask

    task automatic clear_tallies();
        wr_cnt = 0; off_page_rd = 0; first_wr_data = 8'h00; last_wr_data = 8'h00;
    endtask

    task automatic start(input logic [7:0] p, input logic odd, output int sc);
        tick();
        dma_start = 1'b1; dma_page = p; sc = cyc;
        clear_tallies();
        tick();
        dma_start = 1'b0; dma_page = 8'($urandom); cpu_odd_cycle = odd;
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 1000) begin tick(); n++; end
        if (done_cnt == d0) chk("done_timeout", 32'(done_cnt), 32'(d0 + 1));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cpu_rdy"}, 32'(cpu_rdy), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_cs"}, 32'(ppu_reg_cs), 32'd0);
        chk({tag, "_we"}, 32'(ppu_reg_we), 32'd0);
        chk({tag, "_reg_addr"}, 32'(ppu_reg_addr), 32'd0);
        chk({tag, "_data_out"}, 32'(ppu_data_out), 32'd0);
    endtask

    initial begin
        int sc, sc2, d0, n;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + 16'(i)] = 8'(i) ^ 8'hA5;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;
        repeat (3) tick();

        // Page copy from $0200
        d0 = done_cnt;
        start(8'h02, 1'b0, sc);
        wait_done(d0);
        chk("copy_latency", 32'(done_cyc - sc), 32'd514);
        chk("copy_writes", 32'(wr_cnt), 32'd256);
        chk("copy_first_data", 32'(first_wr_data), 32'hA5);
        chk("copy_last_data", 32'(last_wr_data), 32'h5A);
        chk("copy_last_rd", 32'(last_rd), 32'h02FF);

        // Start on an odd cycle
        repeat (2) tick();
        d0 = done_cnt;
        start(8'h02, 1'b1, sc);
        wait_done(d0);
        chk("align_latency", 32'(done_cyc - sc), 32'(514 + ALIGN_ON));
        chk("align_writes", 32'(wr_cnt), 32'd256);

        // dma_start during a transfer is ignored
        repeat (2) tick();
        d0 = done_cnt;
        start(8'h02, 1'b0, sc);
        while (cyc < sc + 100) tick();
        dma_start = 1'b1; dma_page = 8'h03;
        tick();
        dma_start = 1'b0;
        wait_done(d0);
        chk("restart_off_page", 32'(off_page_rd), 32'd0);
        chk("restart_latency", 32'(done_cyc - sc), 32'd514);
        repeat (600) tick();
        chk("restart_one_done", 32'(done_cnt), 32'(d0 + 1));

        // Reset abort at write 37
        d0 = done_cnt;
        start(8'h05, 1'b0, sc);
        n = 0;
        while (!(ppu_reg_we && wr_cnt == 37) && n < 1000) begin tick(); n++; end
        chk("abort_mid_write", 32'(ppu_reg_we), 32'd1);
        #1 rst = 1'b1;
        #1 chk_reset_outputs("abort");
        tick();
        rst = 1'b0;
        repeat (600) tick();
        chk("abort_no_done", 32'(done_cnt), 32'(d0));
        start(8'h06, 1'b0, sc);
        wait_done(d0);
        chk("abort_rerun_writes", 32'(wr_cnt), 32'd256);
        chk("abort_rerun_latency", 32'(done_cyc - sc), 32'd514);

        // Boundary page $FF
        repeat (2) tick();
        d0 = done_cnt;
        start(8'hFF, 1'b0, sc);
        wait_done(d0);
        chk("ff_last_rd", 32'(last_rd), 32'hFFFF);
        chk("ff_off_page", 32'(off_page_rd), 32'd0);
        chk("ff_writes", 32'(wr_cnt), 32'd256);

        // Back-to-back: restart in the done cycle
        repeat (2) tick();
        d0 = done_cnt;
        start(8'h10, 1'b0, sc);
        while (cyc < sc + 514) tick();
        chk("b2b_done_cycle", 32'(done), 32'd1);
        chk("b2b_rdy_in_done", 32'(cpu_rdy), 32'd1);
        dma_start = 1'b1; dma_page = 8'h04; sc2 = cyc;
        clear_tallies();
        tick();
        dma_start = 1'b0; cpu_odd_cycle = 1'b0;
        chk("b2b_halt_busy", 32'(busy), 32'd1);
        chk("b2b_halt_rdy", 32'(cpu_rdy), 32'd0);
        wait_done(d0 + 1);
        chk("b2b_rdy_gap", 32'(last_rdy_run), 32'd1);
        chk("b2b_latency", 32'(done_cyc - sc2), 32'd514);
        chk("b2b_writes", 32'(wr_cnt), 32'd256);
        chk("b2b_last_rd", 32'(last_rd), 32'h04FF);

        // Randomized starts, including ones that land while busy
        d0 = done_cnt;
        for (int i = 0; i < 6000; i++) begin
            tick();
            dma_start = ($urandom_range(0, 199) == 0);
            dma_page  = 8'($urandom);
        end
        tick();
        dma_start = 1'b0;
        repeat (1100) tick();
        chk("random_activity", 32'(done_cnt > d0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- CPU-side initiator that drives the PPU register port. Counterpart to the PPU register interface, which only responds.
- A CPU write of page P to $4014 starts the transfer. The block halts the CPU, reads CPU memory $P00-$PFF, and writes each byte to PPU register OAMDATA (reg addr 4) through the same cs/we/addr/data port the CPU uses.
- Sits between the CPU bus arbiter and the PPU top-level's register port; the arbiter muxes this block's outputs over the CPU's while busy=1.

Parameters:
- XFER_LEN, 256, bytes per transfer (1..256); counter is 9 bits wide.
- OAM_REG_ADDR, 3'd4, PPU register index written each transfer.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- dma_start  input  1  one-cycle pulse: CPU wrote $4014.
- dma_page  input  8  data of the $4014 write; sampled when dma_start=1.
- cpu_odd_cycle  input  1  high on odd CPU cycles (used only with DMA_ALIGN_EN).
- cpu_rdy  output  1  low while the CPU must stall.
- busy  output  1  high while the DMA owns the bus.
- done  output  1  one-cycle pulse after the final write.
- mem_addr  output  16  CPU-space read address.
- mem_rd  output  1  read strobe; data is returned one clock later.
- mem_data_in  input  8  read data, valid the cycle after mem_rd.
- ppu_reg_cs  output  1  PPU register chip select.
- ppu_reg_we  output  1  PPU register write enable.
- ppu_reg_addr  output  3  PPU register index.
- ppu_data_out  output  8  data to the PPU register.

Behaviour:
- Reset values:
  - cpu_rdy=1.
  - busy, done, mem_rd, ppu_reg_cs, ppu_reg_we = 0.
  - mem_addr, ppu_reg_addr, ppu_data_out = 0.
  - State=IDLE; page and count registers = 0.
- States are IDLE, HALT, ALIGN, READ, WRITE.
- IDLE:
  - On dma_start: latch dma_page, clear count, go to HALT.
  - Otherwise hold all outputs at reset values.
- HALT (1 cycle): cpu_rdy=0, busy=1. Go to ALIGN if DMA_ALIGN_EN and cpu_odd_cycle=1; else go to READ.
- ALIGN (1 cycle): idle; go to READ.
- READ:
  - mem_rd=1, mem_addr={page, count[7:0]}.
  - ppu_reg_cs=0, ppu_reg_we=0.
  - Go to WRITE.
- WRITE:
  - ppu_reg_cs=1, ppu_reg_we=1, ppu_reg_addr=OAM_REG_ADDR.
  - ppu_data_out=mem_data_in (combinational pass-through; zero outside WRITE).
  - count increments.
  - If the incremented count == XFER_LEN, go to IDLE and assert done for that next cycle; else go to READ.
- cpu_rdy=0 and busy=1 in every state except IDLE. cpu_rdy returns to 1 in the same cycle done pulses.
- Latency from the dma_start cycle to done: 1 + align + 2*XFER_LEN + 1 cycles.
  - 514 cycles with no alignment cycle, 515 with it (default length).
- Exactly XFER_LEN write pulses per transfer, at addresses $P00..$P(XFER_LEN-1).
- mem_addr never crosses a page boundary: count[7:0] wraps, and page is never incremented.
- dma_start while busy is ignored: page is not re-latched and the transfer is not restarted.
- dma_start in the same cycle done is high is accepted (state is IDLE).
- Reset mid-transfer aborts immediately: all outputs return to reset values and no done pulse is produced.
- Page $FF is legal: addresses $FF00..$FFFF are read.

Optional Feature:
- Macro name: DMA_ALIGN_EN.
- Defined: ALIGN state exists. A start whose HALT cycle sees cpu_odd_cycle=1 takes one extra cycle (NES 513/514-cycle behaviour).
- Undefined: ALIGN is not synthesised, cpu_odd_cycle is ignored, and transfer length is fixed at 2*XFER_LEN+1 busy cycles.

Decomposition:
- Shared package ppu_pkg holds:
  - typedef enum oam_dma_state_t {IDLE, HALT, ALIGN, READ, WRITE}.
  - localparam PPU_REG_OAMDATA = 3'd4.
  - localparam OAM_DMA_ADDR = 16'h4014.
- Single module; no sub-module is natural (one FSM, one 9-bit counter, one page register).

Test Plan:
- Page copy: preload memory $0200+i = i^8'hA5; pulse dma_start with page 8'h02, cpu_odd_cycle=0.
  - Expect 256 writes with ppu_reg_addr=4 and data i^A5 in order.
  - Expect done 514 cycles after start; cpu_rdy low throughout.
- Alignment (DMA_ALIGN_EN defined): same stimulus with cpu_odd_cycle=1 during HALT.
  - First mem_rd one cycle later; done at 515 cycles.
  - With the macro undefined: 514 cycles.
- Ignored restart: pulse dma_start with page 8'h03 at cycle 100 of a page-2 transfer.
  - All 256 reads stay within $0200-$02FF; exactly one done pulse.
- Reset abort: assert reset at write 37.
  - Outputs return to reset values within the same cycle (asynchronous).
  - No done pulse; a new start afterwards runs a full 256-byte transfer.
- Boundary page: page 8'hFF.
  - Last read at $FFFF; count wraps without touching $0000.
  - Exactly 256 ppu_reg_we pulses.
- Back-to-back: dma_start asserted in the done cycle with page 8'h04.
  - Second transfer starts, with HALT in the next cycle.
  - cpu_rdy is high for exactly one cycle between the two transfers.
